// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch front-end        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int unsigned     XLEN       = 32;
    localparam logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, hence one bit beyond the index width.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO of fetch entries with push/pop/flush    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  fetch_entry_t                  i_push_data,
    input  logic                          i_pop,
    input  logic                          i_flush,
    output fetch_entry_t                  o_head,
    output logic [cnt_width(DEPTH)-1:0]   o_count,
    output logic                          o_empty,
    output logic                          o_full
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = cnt_width(DEPTH);

    fetch_entry_t        r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + c_CW'(i_push) - c_CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : PC owner, credit-limited fetch issue, in-order buffer   |
// | Optional macro FETCH_PERF_COUNTERS_EN adds perf counter outputs.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr_data,
    output logic [31:0] o_instr_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_halted
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stall
`endif
);

    localparam int unsigned  c_CW    = cnt_width(DEPTH);
    localparam logic [c_CW:0] c_DEPTH = (c_CW+1)'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic            r_halt_seen;
    logic            r_halted;

    logic [c_CW-1:0] w_count;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic [c_CW:0]   w_inflight;
    logic            w_redir;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_dropping;
    logic            w_rsp_keep;
    logic            w_rsp_halt;
    logic            w_pop;
    logic [c_CW-1:0] w_out_next;
    logic [31:0]     w_redir_pc;

    // Once halted, a redirect has no effect at all.
    assign w_redir     = i_redirect_valid && !r_halted;
    assign w_redir_pc  = i_redirect_pc & ~32'h3;
    assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_req_valid = rst_n && !r_halt_seen && !w_redir && (w_inflight < c_DEPTH);
    assign w_req_fire  = w_req_valid && i_mem_req_ready;
    assign w_dropping  = (r_drop_cnt != '0);
    assign w_rsp_keep  = i_mem_rsp_valid && !w_redir && !w_dropping;
    assign w_rsp_halt  = w_rsp_keep && (i_mem_rsp_data == HALT_INSTR);
    assign w_out_next  = r_outstanding + c_CW'(w_req_fire) - c_CW'(i_mem_rsp_valid);
    assign w_pop       = o_instr_valid && i_instr_ready;

    assign w_push_data.instr = i_mem_rsp_data;
    assign w_push_data.pc    = r_rsp_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_redir),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_halt_seen   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_redir) begin
                r_fetch_pc  <= w_redir_pc;
                r_rsp_pc    <= w_redir_pc;
                r_halt_seen <= 1'b0;
                // Everything still in flight belongs to the old stream.
                r_drop_cnt  <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_rsp_keep) begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                end
                // A request issued in the halt cycle is counted in w_out_next too.
                if (w_rsp_halt) begin
                    r_halt_seen <= 1'b1;
                    r_drop_cnt  <= w_out_next;
                end else if (i_mem_rsp_valid && w_dropping) begin
                    r_drop_cnt <= r_drop_cnt - c_CW'(1);
                end
            end
            if (w_pop && (w_head.instr == HALT_INSTR)) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign o_mem_req_valid = w_req_valid;
    assign o_mem_req_addr  = r_fetch_pc;
    assign o_instr_valid   = !w_empty && !w_redir;
    assign o_instr_data    = w_empty ? '0 : w_head.instr;
    assign o_instr_pc      = w_empty ? '0 : w_head.pc;
    assign o_halted        = r_halted;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_rsp_keep) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!o_instr_valid && !r_halted) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stall   = r_perf_stall;
`endif

`ifndef SYNTHESIS
    a_no_rsp_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_mem_rsp_valid && w_full));
    a_no_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_mem_rsp_valid && (r_outstanding == '0)));
`endif

endmodule
`default_nettype wire
